// File: rtl/program_loader.sv
// Streaming program loader: receives a length-prefixed, XOR-checksummed byte image,
// writes it into instruction memory and releases the core from reset once it is verified.
module program_loader #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned BOOT_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] word_count
);

    localparam int unsigned CNT_W  = 18;
    localparam int unsigned HOLD_W = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        PAYLOAD,
        CKSUM,
        HOLD,
        RUN,
        ERROR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         len_hi;
    logic [CNT_W-1:0]   total_bytes;
    logic [CNT_W-1:0]   byte_cnt;
    logic [7:0]         xor_acc;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               accept;

    // Byte length is formed at full 18-bit width so oversize lengths never alias small ones.
    logic [CNT_W-1:0]   len_bytes;
    logic               len_zero;
    logic               len_too_big;
    logic               last_payload;
    logic               hold_last;

    assign len_bytes    = {len_hi, rx_data, 2'b00};
    assign len_zero     = ({len_hi, rx_data} == 16'd0);
    assign len_too_big  = (32'(len_bytes) > MEM_BYTES);
    assign last_payload = (byte_cnt == (total_bytes - CNT_W'(1)));
    assign hold_last    = (hold_cnt == HOLD_W'(BOOT_HOLD - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LEN_HI;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and ready decode; ready depends on state only
    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        case (state)
            LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (len_too_big)   state_next = ERROR;
                    else if (len_zero) state_next = CKSUM;
                    else               state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                rx_ready = 1'b1;
                if (rx_valid && last_payload) state_next = CKSUM;
            end
            CKSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = (rx_data == xor_acc) ? HOLD : ERROR;
            end
            HOLD: begin
                if (hold_last) state_next = RUN;
            end
            default: begin
            end
        endcase
        accept = rx_valid && rx_ready;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi      <= 8'h00;
            total_bytes <= '0;
            byte_cnt    <= '0;
            xor_acc     <= 8'h00;
            hold_cnt    <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 8'h00;
            word_count  <= 16'd0;
            core_reset  <= 1'b1;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                LEN_HI: begin
                    if (accept) len_hi <= rx_data;
                end
                LEN_LO: begin
                    if (accept) begin
                        total_bytes <= len_bytes;
                        byte_cnt    <= '0;
                        xor_acc     <= 8'h00;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= 32'(byte_cnt);
                        mem_wdata <= rx_data;
                        byte_cnt  <= byte_cnt + CNT_W'(1);
                        xor_acc   <= xor_acc ^ rx_data;
                        // Word completes with its 4th byte; the count saturates.
                        if ((byte_cnt[1:0] == 2'b11) && (word_count != 16'hFFFF)) begin
                            word_count <= word_count + 16'd1;
                        end
                    end
                end
                CKSUM: begin
                    hold_cnt <= '0;
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (hold_last) begin
                        core_reset <= 1'b0;
                        load_done  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if (state_next == ERROR) load_error <= 1'b1;
        end
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEM_BYTES, default 1024, instruction memory size in bytes.
REQ-002 Parameter BOOT_HOLD, default 4, clock edges core_reset stays high after a good checksum (minimum 1).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 rx_data  input  8  incoming program stream byte.
REQ-006 rx_valid  input  1  rx_data holds a valid byte.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 mem_addr  output  32  byte address into instruction memory.
REQ-009 mem_wdata  output  8  byte to write.
REQ-010 mem_we  output  1  one-cycle byte write strobe.
REQ-011 core_reset  output  1  held high to keep the processor in reset until load completes.
REQ-012 load_done  output  1  program loaded and verified; processor released.
REQ-013 load_error  output  1  sticky error flag.
REQ-014 word_count  output  16  complete 32-bit words written so far.

Function
REQ-015 Stream format SHALL be: length L in words (2 bytes, MSB first), then 4*L payload bytes, then 1 checksum byte.
REQ-016 The checksum SHALL be the XOR of all payload bytes; L=0 expects checksum 0x00.
REQ-017 A byte SHALL be accepted on a posedge where rx_valid=1 and rx_ready=1; rx_valid without rx_ready SHALL be ignored.
REQ-018 States SHALL be LEN_HI, LEN_LO, PAYLOAD, CKSUM, HOLD, RUN, ERROR.
REQ-019 rx_ready SHALL be 1 in LEN_HI, LEN_LO, PAYLOAD and CKSUM, and 0 in HOLD, RUN and ERROR (decoded from state only, no dependence on rx_valid).
REQ-020 LEN_HI -> LEN_LO on acceptance; LEN_LO -> PAYLOAD if L>0, CKSUM if L=0, ERROR if 4*L > MEM_BYTES (computed at 18-bit width, no truncation).
REQ-021 In PAYLOAD, the n-th accepted byte (n from 0) SHALL produce mem_we=1, mem_addr=n, mem_wdata=byte on the cycle after acceptance (1-cycle latency), giving big-endian word layout.
REQ-022 mem_we SHALL be 0 in every cycle not following a payload acceptance; mem_addr and mem_wdata SHALL hold their last values.
REQ-023 word_count SHALL increment by 1 in the same cycle as the mem_we of every 4th payload byte, and saturate at 0xFFFF.
REQ-024 After the 4*L-th payload byte is accepted, the state SHALL be CKSUM on the next cycle, with no idle cycle.
REQ-025 CKSUM -> HOLD on acceptance if the byte equals the running XOR; otherwise -> ERROR.
REQ-026 HOLD SHALL count BOOT_HOLD edges, then -> RUN; core_reset=0 and load_done=1 from the BOOT_HOLD-th edge after the checksum acceptance edge onward.
REQ-027 RUN and ERROR SHALL be terminal until reset; in ERROR, load_error=1 and core_reset=1.
REQ-028 Back-to-back bytes (rx_valid held high) SHALL be accepted at one per cycle with no bubbles through LEN_HI..CKSUM.

Reset
REQ-029 On a posedge with reset=1: state=LEN_HI, running XOR=0, byte counter=0, word_count=0, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, load_done=0, load_error=0; rx_ready=1 from the following cycle.
REQ-030 Reset SHALL take priority over an acceptance on the same edge; that byte is dropped.
REQ-031 Reset mid-load SHALL discard partial progress without clearing memory; the next byte is treated as LEN_HI.
REQ-032 Reset asserted in RUN SHALL reassert core_reset=1 and clear load_done on that edge.

Verification
REQ-033 L=0x0001, bytes 20 08 00 05, checksum 0x2D -> writes addr 0..3 = 20,08,00,05; word_count=1; core_reset falls exactly 4 edges after checksum acceptance; load_done=1.
REQ-034 Same stream with checksum 0x2C -> load_error=1, core_reset stays 1, rx_ready=0, and no further mem_we under continued rx_valid.
REQ-035 L=0x0101 (1028 bytes > 1024) -> ERROR one cycle after the second length byte; zero mem_we pulses.
REQ-036 L=2 with rx_valid toggling 1/0 every cycle -> 8 writes at addr 0..7 in order, each exactly 1 cycle after its acceptance; word_count sequence 0,1,2.
REQ-037 Reset asserted after 3 payload bytes, then a new stream L=0 with checksum 0x00 -> word_count=0; load_done after BOOT_HOLD edges; the earlier bytes remain in memory.
REQ-038 Length 00 00 followed by checksum 0x00, with rx_valid held high throughout -> 3 accepts in 3 consecutive cycles; mem_we never asserted.
